wb_test_memory: RTL and testbench

Wishbone classic slave that answers the test sequencer's bus master. It holds the program memory and the register window that the sequencer writes with SET and polls with WAIT. A host-side load port fills program memory. A DUT-side port lets the hardware under test update and observe register values. Unmapped addresses are always acknowledged, so the master never hangs, and are flagged on sticky status outputs.

---
 rtl/wb_test_memory.sv | 162 ++++++++++++++++
 tb/tb_wb_test_memory.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_test_memory.sv
// Wishbone classic slave for the test sequencer: program memory, a register window,
// a host load port, a DUT-side register port and sticky flags for unmapped accesses.
module wb_test_memory #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int PROGMEM_START = 'h10000,
    parameter int PROG_DEPTH    = 256,
    parameter int REGMEM_START  = 'h00000,
    parameter int REG_COUNT     = 16,
    parameter int WAIT_STATES   = 0,
    localparam int PIW = $clog2(PROG_DEPTH),
    localparam int RIW = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] wbAdrI,
    input  logic [15:0]              wbDatI,
    output logic [15:0]              wbDatO,
    input  logic                     wbCycI,
    input  logic                     wbStbI,
    input  logic                     wbWeI,
    output logic                     wbAckO,
    input  logic                     loadEn,
    input  logic [PIW-1:0]           loadAddr,
    input  logic [15:0]              loadData,
    input  logic                     dutWe,
    input  logic [RIW-1:0]           dutIdx,
    input  logic [15:0]              dutWrData,
    output logic [15:0]              dutRdData,
    output logic                     badAccess,
    output logic [ADDRESS_WIDTH-1:0] badAddr
);

    // Bus handshake: a request is cyc&stb sampled in IDLE; wbAckO is high for exactly
    // the one cycle spent in ACK, and no new request is sampled while in ACK.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int AW1 = ADDRESS_WIDTH + 1;
    localparam logic [AW1-1:0] PROG_LO = AW1'(PROGMEM_START);
    localparam logic [AW1-1:0] PROG_HI = AW1'(PROGMEM_START + PROG_DEPTH);
    localparam logic [AW1-1:0] REG_LO  = AW1'(REGMEM_START);
    localparam logic [AW1-1:0] REG_HI  = AW1'(REGMEM_START + REG_COUNT);

    state_t state, stateNext;
    logic [3:0] waitCnt, waitCntNext;
    logic latch, enterAck;

    logic [ADDRESS_WIDTH-1:0] reqAdr;
    logic                     reqWe;
    logic [15:0]              reqDat;

    logic [ADDRESS_WIDTH-1:0] actAdr;
    logic                     actWe;
    logic [15:0]              actDat;
    logic [AW1-1:0]           adrWide;
    logic                     progHit, regHit;
    logic [PIW-1:0]           progIdx;
    logic [RIW-1:0]           regIdx;

    logic [15:0] progMem [PROG_DEPTH];
    logic [15:0] regs    [REG_COUNT];

    // With zero wait states the ack is entered on the sampling edge itself, so the
    // live bus inputs stand in for the not-yet-latched request.
    always_comb begin
        actAdr = (state == S_IDLE) ? wbAdrI : reqAdr;
        actWe  = (state == S_IDLE) ? wbWeI  : reqWe;
        actDat = (state == S_IDLE) ? wbDatI : reqDat;
    end

    always_comb begin
        adrWide = {1'b0, actAdr};
        regHit  = (adrWide >= REG_LO) && (adrWide < REG_HI);
        progHit = !regHit && (adrWide >= PROG_LO) && (adrWide < PROG_HI);
        progIdx = PIW'(adrWide - PROG_LO);
        regIdx  = RIW'(adrWide - REG_LO);
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        latch       = 1'b0;
        enterAck    = 1'b0;
        case (state)
            S_IDLE: begin
                if (wbCycI && wbStbI) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        stateNext = S_ACK;
                        enterAck  = 1'b1;
                    end else begin
                        stateNext   = S_WAIT;
                        waitCntNext = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!(wbCycI && wbStbI)) begin
                    stateNext = S_IDLE;
                end else if (waitCnt == 4'd0) begin
                    stateNext = S_ACK;
                    enterAck  = 1'b1;
                end else begin
                    waitCntNext = waitCnt - 4'd1;
                end
            end
            S_ACK:   stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            waitCnt   <= 4'd0;
            reqAdr    <= '0;
            reqWe     <= 1'b0;
            reqDat    <= 16'h0000;
            wbDatO    <= 16'h0000;
            badAccess <= 1'b0;
            badAddr   <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (latch) begin
                reqAdr <= wbAdrI;
                reqWe  <= wbWeI;
                reqDat <= wbDatI;
            end
            if (enterAck) begin
                if (!actWe) begin
                    if (regHit)       wbDatO <= regs[regIdx];
                    else if (progHit) wbDatO <= progMem[progIdx];
                    else              wbDatO <= 16'h0000;
                end
                if (!regHit && !progHit) begin
                    badAccess <= 1'b1;
                    if (!badAccess) badAddr <= actAdr;
                end
            end
        end
    end

    // Program memory has no reset so a loaded program survives a sequencer restart;
    // the load port is the later assignment and wins a same-index collision.
    always_ff @(posedge clk) begin
        if (!rst && enterAck && actWe && progHit) progMem[progIdx] <= actDat;
        if (loadEn) progMem[loadAddr] <= loadData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 16'h0000;
        end else begin
            if (enterAck && actWe && regHit) regs[regIdx] <= actDat;
            if (dutWe) regs[dutIdx] <= dutWrData;
        end
    end

    assign wbAckO    = (state == S_ACK);
    assign dutRdData = regs[dutIdx];

endmodule

// File: tb/tb_wb_test_memory.sv
// Directed bench for wb_test_memory: one instance with no wait states, one with three.
module tb_wb_test_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        loadEn;
    logic [7:0]  loadAddr;
    logic [15:0] loadData;

    // Instance A: WAIT_STATES=0
    logic [23:0] aAdr, aBadAddr;
    logic [15:0] aDatI, aDatO, aDutWr, aDutRd;
    logic        aCyc, aStb, aWe, aAck, aDutWe, aBad;
    logic [3:0]  aDutIdx;

    // Instance B: WAIT_STATES=3
    logic [23:0] bAdr, bBadAddr;
    logic [15:0] bDatI, bDatO, bDutWr, bDutRd;
    logic        bCyc, bStb, bWe, bAck, bDutWe, bBad;
    logic [3:0]  bDutIdx;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [15:0] progVals [3];

    wb_test_memory #(.WAIT_STATES(0)) m0 (
        .clk(clk), .rst(rst), .wbAdrI(aAdr), .wbDatI(aDatI), .wbDatO(aDatO),
        .wbCycI(aCyc), .wbStbI(aStb), .wbWeI(aWe), .wbAckO(aAck),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
        .dutWe(aDutWe), .dutIdx(aDutIdx), .dutWrData(aDutWr), .dutRdData(aDutRd),
        .badAccess(aBad), .badAddr(aBadAddr)
    );

    wb_test_memory #(.WAIT_STATES(3)) m3 (
        .clk(clk), .rst(rst), .wbAdrI(bAdr), .wbDatI(bDatI), .wbDatO(bDatO),
        .wbCycI(bCyc), .wbStbI(bStb), .wbWeI(bWe), .wbAckO(bAck),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
        .dutWe(bDutWe), .dutIdx(bDutIdx), .dutWrData(bDutWr), .dutRdData(bDutRd),
        .badAccess(bBad), .badAddr(bBadAddr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a request and returns at the first negedge where ack is seen
    // (or after the cycle budget); lat counts negedges from drive to ack.
    task automatic busA(input logic [23:0] adr, input logic we, input logic [15:0] dat,
                        output int l);
        aAdr = adr; aWe = we; aDatI = dat; aCyc = 1'b1; aStb = 1'b1;
        l = 0;
        do begin @(negedge clk); l++; end while (!aAck && l < 20);
    endtask

    task automatic busB(input logic [23:0] adr, input logic we, input logic [15:0] dat,
                        output int l);
        bAdr = adr; bWe = we; bDatI = dat; bCyc = 1'b1; bStb = 1'b1;
        l = 0;
        do begin @(negedge clk); l++; end while (!bAck && l < 20);
    endtask

    task automatic idleA();
        aCyc = 1'b0; aStb = 1'b0; aWe = 1'b0;
        @(negedge clk);
    endtask

    task automatic idleB();
        bCyc = 1'b0; bStb = 1'b0; bWe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        progVals[0] = 16'd1; progVals[1] = 16'd5; progVals[2] = 16'd9;
        rst = 1'b1; loadEn = 1'b0; loadAddr = '0; loadData = '0;
        aAdr = '0; aDatI = '0; aCyc = 0; aStb = 0; aWe = 0; aDutWe = 0; aDutIdx = '0; aDutWr = '0;
        bAdr = '0; bDatI = '0; bCyc = 0; bStb = 0; bWe = 0; bDutWe = 0; bDutIdx = '0; bDutWr = '0;

        // Program load while reset is held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            loadEn = 1'b1; loadAddr = 8'(i); loadData = progVals[i];
        end
        @(negedge clk);
        loadEn = 1'b0; rst = 1'b0;
        @(negedge clk);

        check("reset ack", {31'd0, aAck}, 32'd0);
        check("reset datO", {16'd0, aDatO}, 32'd0);
        check("reset badAccess", {31'd0, aBad}, 32'd0);
        check("reset badAddr", {8'd0, aBadAddr}, 32'd0);
        check("reset reg0", {16'd0, aDutRd}, 32'd0);

        // Back-to-back reads with stb held, address swapped on the ack edge
        aAdr = 24'h10000; aWe = 1'b0; aCyc = 1'b1; aStb = 1'b1;
        @(negedge clk);
        check("b2b ack1", {31'd0, aAck}, 32'd1);
        check("b2b data1", {16'd0, aDatO}, 32'd1);
        aAdr = 24'h10001;
        @(negedge clk);
        check("b2b gap ack", {31'd0, aAck}, 32'd0);
        check("b2b gap data hold", {16'd0, aDatO}, 32'd1);
        @(negedge clk);
        check("b2b ack2", {31'd0, aAck}, 32'd1);
        check("b2b data2", {16'd0, aDatO}, 32'd5);
        idleA();

        // Register write then readback
        aDutIdx = 4'd3;
        busA(24'h00003, 1'b1, 16'hBEEF, lat);
        check("write latency", lat, 32'd1);
        check("write dutRdData", {16'd0, aDutRd}, 32'h0000BEEF);
        check("write keeps datO", {16'd0, aDatO}, 32'd5);
        idleA();
        check("ack one cycle", {31'd0, aAck}, 32'd0);
        busA(24'h00003, 1'b0, 16'h0, lat);
        check("read reg3", {16'd0, aDatO}, 32'h0000BEEF);
        idleA();

        // Same-edge collision, same index: DUT port wins
        aDutWe = 1'b1; aDutIdx = 4'd2; aDutWr = 16'h2222;
        busA(24'h00002, 1'b1, 16'h1111, lat);
        aDutWe = 1'b0;
        check("collide same idx", {16'd0, aDutRd}, 32'h00002222);
        idleA();

        // Same-edge, different indices: both commit
        aDutWe = 1'b1; aDutIdx = 4'd4; aDutWr = 16'h2222;
        busA(24'h00002, 1'b1, 16'h1111, lat);
        aDutWe = 1'b0;
        check("collide reg4", {16'd0, aDutRd}, 32'h00002222);
        aDutIdx = 4'd2;
        #1;
        check("collide reg2", {16'd0, aDutRd}, 32'h00001111);
        idleA();

        // Unmapped read then write
        busA(24'h20000, 1'b0, 16'h0, lat);
        check("unmapped read acked", lat, 32'd1);
        check("unmapped read data", {16'd0, aDatO}, 32'd0);
        check("badAccess set", {31'd0, aBad}, 32'd1);
        check("badAddr first", {8'd0, aBadAddr}, 32'h20000);
        idleA();
        busA(24'h30000, 1'b1, 16'h1234, lat);
        check("unmapped write acked", lat, 32'd1);
        idleA();
        check("badAddr sticky", {8'd0, aBadAddr}, 32'h20000);
        aDutIdx = 4'd0;
        #1;
        check("unmapped write no reg0", {16'd0, aDutRd}, 32'd0);
        aDutIdx = 4'd3;
        #1;
        check("reg3 untouched", {16'd0, aDutRd}, 32'h0000BEEF);

        // Three wait states
        @(negedge clk);
        busB(24'h10002, 1'b0, 16'h0, lat);
        check("ws3 latency", lat, 32'd4);
        check("ws3 data", {16'd0, bDatO}, 32'd9);
        idleB();
        check("ws3 ack one cycle", {31'd0, bAck}, 32'd0);

        // Drop stb mid-wait on a read
        bAdr = 24'h10000; bWe = 1'b0; bCyc = 1'b1; bStb = 1'b1;
        @(negedge clk);
        check("abort ack c1", {31'd0, bAck}, 32'd0);
        @(negedge clk);
        check("abort ack c2", {31'd0, bAck}, 32'd0);
        bCyc = 1'b0; bStb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort no ack", {31'd0, bAck}, 32'd0);
        end
        check("abort datO held", {16'd0, bDatO}, 32'd9);

        // Drop stb mid-wait on a write: nothing committed
        bAdr = 24'h00006; bWe = 1'b1; bDatI = 16'h6666; bCyc = 1'b1; bStb = 1'b1;
        repeat (2) @(negedge clk);
        idleB();
        repeat (3) @(negedge clk);
        bDutIdx = 4'd6;
        #1;
        check("abort write discarded", {16'd0, bDutRd}, 32'd0);

        // Back in IDLE: a fresh read has full latency
        busB(24'h10001, 1'b0, 16'h0, lat);
        check("after abort latency", lat, 32'd4);
        check("after abort data", {16'd0, bDatO}, 32'd5);
        idleB();

        // Set badAccess and reg1, then reset in the middle of a write to reg5
        busB(24'h40000, 1'b0, 16'h0, lat);
        idleB();
        check("ws3 badAccess", {31'd0, bBad}, 32'd1);
        busB(24'h00001, 1'b1, 16'h0007, lat);
        idleB();
        bDutIdx = 4'd1;
        #1;
        check("reg1 written", {16'd0, bDutRd}, 32'd7);
        @(negedge clk);
        bAdr = 24'h00005; bWe = 1'b1; bDatI = 16'hAAAA; bCyc = 1'b1; bStb = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bCyc = 1'b0; bStb = 1'b0; bWe = 1'b0;
        check("rst ack", {31'd0, bAck}, 32'd0);
        check("rst badAccess", {31'd0, bBad}, 32'd0);
        check("rst reg1", {16'd0, bDutRd}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst no late ack", {31'd0, bAck}, 32'd0);
        end
        bDutIdx = 4'd5;
        #1;
        check("rst reg5", {16'd0, bDutRd}, 32'd0);

        // Program memory survives reset
        busB(24'h10000, 1'b0, 16'h0, lat);
        check("prog0 kept", {16'd0, bDatO}, 32'd1);
        idleB();
        busB(24'h10001, 1'b0, 16'h0, lat);
        check("prog1 kept", {16'd0, bDatO}, 32'd5);
        idleB();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
